// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear scan controller.
package bilinear_pkg;

  localparam int unsigned Q_FRAC    = 8;
  localparam int unsigned DIM_W_DEF = 11;

  typedef logic [DIM_W_DEF+Q_FRAC-1:0] coord_t;

  typedef enum logic [2:0] {IDLE, CALC, FETCH, ISSUE, WAIT, OUTPUT, DONE} state_t;

  typedef enum logic [1:0] {F00, F10, F01, F11} fetch_idx_t;

endpackage

// File: rtl/bilinear_scan_ctrl_if.sv
// Memory, datapath and output-stream signals of the bilinear scan controller.
interface bilinear_scan_ctrl_if #(
  parameter int unsigned ADDR_W = 22
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              ip_valid_in;
  logic [7:0]        ip_I00, ip_I10, ip_I01, ip_I11;
  logic [7:0]        ip_alpha, ip_beta;
  logic              ip_valid_out;
  logic [7:0]        ip_pixel_out;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_pixel;
  logic              out_last;

  modport master (
    output mem_req, mem_addr, ip_valid_in, ip_I00, ip_I10, ip_I01, ip_I11,
           ip_alpha, ip_beta, out_valid, out_pixel, out_last,
    input  mem_ack, mem_rdata, ip_valid_out, ip_pixel_out, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, ip_valid_in, ip_I00, ip_I10, ip_I01, ip_I11,
           ip_alpha, ip_beta, out_valid, out_pixel, out_last,
    output mem_ack, mem_rdata, ip_valid_out, ip_pixel_out, out_ready
  );
endinterface

// File: rtl/bilinear_coord_gen.sv
// Raster counters and Q8.8 source-coordinate accumulators; neighbour
// coordinates and fractions are derived combinationally from the accumulators.
module bilinear_coord_gen
  import bilinear_pkg::*;
#(
  parameter int unsigned DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [DIM_W-1:0] i_src_w,
  input  logic [DIM_W-1:0] i_src_h,
  input  logic [DIM_W-1:0] i_dst_w,
  input  logic [DIM_W-1:0] i_dst_h,
  input  logic [15:0]      i_step_x,
  input  logic [15:0]      i_step_y,
  output logic [DIM_W-1:0] o_x0_c,
  output logic [DIM_W-1:0] o_x1_c,
  output logic [DIM_W-1:0] o_y0_c,
  output logic [DIM_W-1:0] o_y1_c,
  output logic [7:0]       o_alpha_c,
  output logic [7:0]       o_beta_c,
  output logic             o_last_c
);
  localparam int unsigned ACC_W = DIM_W + Q_FRAC;

  logic [ACC_W-1:0] r_acc_x, r_acc_y;
  logic [DIM_W-1:0] r_dx, r_dy;
  logic [DIM_W-1:0] w_x0_raw, w_y0_raw, w_src_w_m1, w_src_h_m1;
  logic             w_last_col, w_last_row;

  // Overflowing accumulation pins at all-ones; x0/y0 clamping then bounds it.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [15:0] s);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + (ACC_W+1)'(s);
    return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  endfunction

  assign w_src_w_m1 = i_src_w - DIM_W'(1);
  assign w_src_h_m1 = i_src_h - DIM_W'(1);
  assign w_x0_raw   = r_acc_x[ACC_W-1:Q_FRAC];
  assign w_y0_raw   = r_acc_y[ACC_W-1:Q_FRAC];
  assign w_last_col = (r_dx == i_dst_w - DIM_W'(1));
  assign w_last_row = (r_dy == i_dst_h - DIM_W'(1));

  assign o_x0_c    = (w_x0_raw > w_src_w_m1) ? w_src_w_m1 : w_x0_raw;
  assign o_y0_c    = (w_y0_raw > w_src_h_m1) ? w_src_h_m1 : w_y0_raw;
  assign o_x1_c    = (o_x0_c < w_src_w_m1) ? o_x0_c + DIM_W'(1) : w_src_w_m1;
  assign o_y1_c    = (o_y0_c < w_src_h_m1) ? o_y0_c + DIM_W'(1) : w_src_h_m1;
  assign o_alpha_c = r_acc_x[Q_FRAC-1:0];
  assign o_beta_c  = r_acc_y[Q_FRAC-1:0];
  assign o_last_c  = w_last_col && w_last_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
    end else if (i_clear) begin
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
    end else if (i_step) begin
      if (w_last_col) begin
        r_dx    <= '0;
        r_acc_x <= '0;
        r_dy    <= r_dy + DIM_W'(1);
        r_acc_y <= sat_add(r_acc_y, i_step_y);
      end else begin
        r_dx    <= r_dx + DIM_W'(1);
        r_acc_x <= sat_add(r_acc_x, i_step_x);
      end
    end
  end

endmodule

// File: rtl/bilinear_scan_ctrl.sv
// Bilinear scaler sequencer: walks the destination frame, fetches four
// neighbours per pixel, drives the interpolation datapath and streams results.
// Optional macro BILINEAR_FETCH_REUSE_EN skips fetches when (x0,y0) repeats.
module bilinear_scan_ctrl
  import bilinear_pkg::*;
#(
  parameter int unsigned DIM_W     = DIM_W_DEF,
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     src_w,
  input  logic [DIM_W-1:0]     src_h,
  input  logic [DIM_W-1:0]     dst_w,
  input  logic [DIM_W-1:0]     dst_h,
  input  logic [15:0]          step_x,
  input  logic [15:0]          step_y,
  output logic                 busy,
  output logic                 done,
  bilinear_scan_ctrl_if.master bus
);
  state_t           r_state, w_state_nxt;
  fetch_idx_t       r_fidx, w_fidx_nxt, w_fsel;
  logic [DIM_W-1:0] r_src_w, r_src_h, r_dst_w, r_dst_h;
  logic [15:0]      r_step_x, r_step_y;
  logic [DIM_W-1:0] w_x0, w_x1, w_y0, w_y1, w_fx, w_fy;
  logic [7:0]       w_alpha, w_beta;
  logic             w_last, w_clear, w_step, w_reuse;
  logic [ADDR_W-1:0] w_addr;

  logic              r_busy, r_done, r_mem_req, r_ip_valid_in, r_out_valid, r_out_last;
  logic              w_mem_req_nxt, w_ip_valid_nxt, w_out_valid_nxt, w_out_last_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [3:0][7:0]   r_pix, w_pix_nxt;
  logic [7:0]        r_alpha, r_beta, r_out_pixel;
  logic [7:0]        w_alpha_nxt, w_beta_nxt, w_out_pixel_nxt;

  assign w_clear = (r_state == IDLE) && start;
  assign w_step  = (r_state == OUTPUT) && bus.out_ready;

  // Frame configuration is captured only when a frame is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_w  <= '0;
      r_src_h  <= '0;
      r_dst_w  <= '0;
      r_dst_h  <= '0;
      r_step_x <= '0;
      r_step_y <= '0;
    end else if (w_clear) begin
      r_src_w  <= src_w;
      r_src_h  <= src_h;
      r_dst_w  <= dst_w;
      r_dst_h  <= dst_h;
      r_step_x <= step_x;
      r_step_y <= step_y;
    end
  end

  bilinear_coord_gen #(.DIM_W(DIM_W)) u_coord (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_step    (w_step),
    .i_src_w   (r_src_w),
    .i_src_h   (r_src_h),
    .i_dst_w   (r_dst_w),
    .i_dst_h   (r_dst_h),
    .i_step_x  (r_step_x),
    .i_step_y  (r_step_y),
    .o_x0_c    (w_x0),
    .o_x1_c    (w_x1),
    .o_y0_c    (w_y0),
    .o_y1_c    (w_y1),
    .o_alpha_c (w_alpha),
    .o_beta_c  (w_beta),
    .o_last_c  (w_last)
  );

  // Address of the next read: F00 when leaving CALC, else the pending index.
  assign w_fsel = (r_state == FETCH) ? r_fidx : F00;
  assign w_fx   = (w_fsel == F10 || w_fsel == F11) ? w_x1 : w_x0;
  assign w_fy   = (w_fsel == F01 || w_fsel == F11) ? w_y1 : w_y0;
  assign w_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(w_fy) * ADDR_W'(r_src_w) + ADDR_W'(w_fx);

`ifdef BILINEAR_FETCH_REUSE_EN
  logic             r_prev_ok;
  logic [DIM_W-1:0] r_prev_x0, r_prev_y0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_ok <= 1'b0;
      r_prev_x0 <= '0;
      r_prev_y0 <= '0;
    end else if (w_clear) begin
      r_prev_ok <= 1'b0;
    end else if (r_state == CALC && !w_reuse) begin
      r_prev_ok <= 1'b1;
      r_prev_x0 <= w_x0;
      r_prev_y0 <= w_y0;
    end
  end

  assign w_reuse = r_prev_ok && (w_x0 == r_prev_x0) && (w_y0 == r_prev_y0);
`else
  assign w_reuse = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_fidx_nxt      = r_fidx;
    w_mem_req_nxt   = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_ip_valid_nxt  = 1'b0;
    w_pix_nxt       = r_pix;
    w_alpha_nxt     = r_alpha;
    w_beta_nxt      = r_beta;
    w_out_valid_nxt = r_out_valid;
    w_out_pixel_nxt = r_out_pixel;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      IDLE: if (start) w_state_nxt = (dst_w == '0 || dst_h == '0) ? DONE : CALC;
      CALC: begin
        w_alpha_nxt = w_alpha;
        w_beta_nxt  = w_beta;
        if (w_reuse) begin
          w_state_nxt    = ISSUE;
          w_ip_valid_nxt = 1'b1;
        end else begin
          w_state_nxt    = FETCH;
          w_fidx_nxt     = F00;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_addr;
        end
      end
      FETCH: begin
        if (!r_mem_req) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_addr;
        end else if (bus.mem_ack) begin
          w_pix_nxt[r_fidx] = bus.mem_rdata;
          if (r_fidx == F11) begin
            w_state_nxt    = ISSUE;
            w_ip_valid_nxt = 1'b1;
          end else begin
            w_fidx_nxt = fetch_idx_t'(2'(r_fidx + 2'd1));
          end
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: if (bus.ip_valid_out) begin
        w_state_nxt     = OUTPUT;
        w_out_valid_nxt = 1'b1;
        w_out_pixel_nxt = bus.ip_pixel_out;
        w_out_last_nxt  = w_last;
      end
      OUTPUT: if (bus.out_ready) begin
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        w_state_nxt     = w_last ? DONE : CALC;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_fidx        <= F00;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_ip_valid_in <= 1'b0;
      r_pix         <= '0;
      r_alpha       <= '0;
      r_beta        <= '0;
      r_out_valid   <= 1'b0;
      r_out_pixel   <= '0;
      r_out_last    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fidx        <= w_fidx_nxt;
      r_busy        <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
      r_done        <= (w_state_nxt == DONE);
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_ip_valid_in <= w_ip_valid_nxt;
      r_pix         <= w_pix_nxt;
      r_alpha       <= w_alpha_nxt;
      r_beta        <= w_beta_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_pixel   <= w_out_pixel_nxt;
      r_out_last    <= w_out_last_nxt;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.ip_valid_in = r_ip_valid_in;
  assign bus.ip_I00      = r_pix[F00];
  assign bus.ip_I10      = r_pix[F10];
  assign bus.ip_I01      = r_pix[F01];
  assign bus.ip_I11      = r_pix[F11];
  assign bus.ip_alpha    = r_alpha;
  assign bus.ip_beta     = r_beta;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_pixel   = r_out_pixel;
  assign bus.out_last    = r_out_last;

endmodule

// File: tb/tb_bilinear_scan_ctrl.sv
// Directed bench for bilinear_scan_ctrl with a 1-cycle-ack memory and a
// single-cycle bilinear datapath model.
module tb_bilinear_scan_ctrl;
  localparam int unsigned DIM_W  = 11;
  localparam int unsigned ADDR_W = 22;
`ifdef BILINEAR_FETCH_REUSE_EN
  localparam int EXP_READS = 32;
`else
  localparam int EXP_READS = 64;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DIM_W-1:0] src_w, src_h, dst_w, dst_h;
  logic [15:0]      step_x, step_y;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  logic [7:0]        mem [16];
  logic [7:0]        got_pix [$];
  logic              got_last [$];
  logic [ADDR_W-1:0] rd_addr [$];
  int                rd_cnt;
  int                done_cnt;
  logic [7:0]        exp_frame [16] = '{10, 15, 20, 20, 20, 25, 30, 30,
                                        30, 35, 40, 40, 30, 35, 40, 40};

  always #5 clk = ~clk;

  bilinear_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  bilinear_scan_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .src_w  (src_w),
    .src_h  (src_h),
    .dst_w  (dst_w),
    .dst_h  (dst_h),
    .step_x (step_x),
    .step_y (step_y),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  function automatic logic [7:0] interp(input logic [7:0] a00, a10, a01, a11, al, be);
    int unsigned ia, ib, s;
    ia = 32'(al);
    ib = 32'(be);
    s = a00 * (256 - ia) * (256 - ib) + a10 * ia * (256 - ib)
      + a01 * (256 - ia) * ib + a11 * ia * ib;
    return 8'(s >> 16);
  endfunction

  // Memory: acks one cycle after a request is seen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= 8'd0;
    end else if (bus.mem_req && !bus.mem_ack) begin
      bus.mem_ack   <= 1'b1;
      bus.mem_rdata <= mem[bus.mem_addr[3:0]];
    end else begin
      bus.mem_ack <= 1'b0;
    end
  end

  // Interpolation datapath: valid_in -> valid_out one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ip_valid_out <= 1'b0;
      bus.ip_pixel_out <= 8'd0;
    end else begin
      bus.ip_valid_out <= bus.ip_valid_in;
      if (bus.ip_valid_in)
        bus.ip_pixel_out <= interp(bus.ip_I00, bus.ip_I10, bus.ip_I01, bus.ip_I11,
                                   bus.ip_alpha, bus.ip_beta);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        got_pix.push_back(bus.out_pixel);
        got_last.push_back(bus.out_last);
      end
      if (done) done_cnt++;
      if (bus.mem_req && bus.mem_ack) begin
        rd_cnt++;
        rd_addr.push_back(bus.mem_addr);
      end
    end
  end

  task automatic clear_logs();
    got_pix.delete();
    got_last.delete();
    rd_addr.delete();
    rd_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic start_frame(input int sw, sh, dw, dh, input logic [15:0] sx, sy);
    @(negedge clk);
    src_w = DIM_W'(sw); src_h = DIM_W'(sh);
    dst_w = DIM_W'(dw); dst_h = DIM_W'(dh);
    step_x = sx; step_y = sy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %0h expected 0", bus.mem_addr); end
    checks++; if (bus.ip_valid_in !== 1'b0) begin errors++; $display("FAIL rst_ip_valid: got %b expected 0", bus.ip_valid_in); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", bus.out_last); end
    checks++; if (bus.out_pixel !== 8'd0) begin errors++; $display("FAIL rst_out_pixel: got %0d expected 0", bus.out_pixel); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_4x4();
    bit to;
    clear_logs();
    start_frame(2, 2, 4, 4, 16'h0080, 16'h0080);
    wait_done(3000, to);
    repeat (3) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL f4_timeout: done not seen, got %0d pixels expected 16", got_pix.size()); end
    checks++; if (got_pix.size() != 16) begin errors++; $display("FAIL f4_count: got %0d expected 16", got_pix.size()); end
    for (int i = 0; i < 16 && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_frame[i]) begin errors++; $display("FAIL f4_pix[%0d]: got %0d expected %0d", i, got_pix[i], exp_frame[i]); end
      checks++;
      if (got_last[i] !== (i == 15)) begin errors++; $display("FAIL f4_last[%0d]: got %b expected %b", i, got_last[i], i == 15); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL f4_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (rd_cnt != EXP_READS) begin errors++; $display("FAIL f4_reads: got %0d expected %0d", rd_cnt, EXP_READS); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL f4_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_single_pixel();
    bit to;
    clear_logs();
    start_frame(2, 2, 1, 1, 16'h0100, 16'h0100);
    wait_done(1000, to);
    repeat (2) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL sp_timeout: done not seen, got %0d pixels expected 1", got_pix.size()); end
    checks++; if (got_pix.size() != 1) begin errors++; $display("FAIL sp_count: got %0d expected 1", got_pix.size()); end
    if (got_pix.size() > 0) begin
      checks++; if (got_pix[0] !== 8'd10) begin errors++; $display("FAIL sp_pix: got %0d expected 10", got_pix[0]); end
      checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL sp_last: got %b expected 1", got_last[0]); end
    end
    checks++; if (rd_cnt != 4) begin errors++; $display("FAIL sp_reads: got %0d expected 4", rd_cnt); end
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
      checks++;
      if (rd_addr[i] !== ADDR_W'(i)) begin errors++; $display("FAIL sp_addr[%0d]: got %0d expected %0d", i, rd_addr[i], i); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int n;
    clear_logs();
    start_frame(2, 2, 4, 4, 16'h0080, 16'h0080);
    n = 0;
    while (got_pix.size() < 1 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (got_pix.size() < 1) begin errors++; $display("FAIL bp_first: got %0d pixels expected 1", got_pix.size()); end
    bus.out_ready = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", bus.out_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_pixel !== 8'd15) begin errors++; $display("FAIL bp_hold_pix[%0d]: got %0d expected 15", i, bus.out_pixel); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bp_mem_req[%0d]: got %b expected 0", i, bus.mem_req); end
      @(negedge clk);
    end
    checks++; if (got_pix.size() != 1) begin errors++; $display("FAIL bp_stalled: got %0d accepted expected 1", got_pix.size()); end
    bus.out_ready = 1'b1;
    wait_done(3000, to);
    repeat (2) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: done not seen, got %0d pixels expected 16", got_pix.size()); end
    checks++; if (got_pix.size() != 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", got_pix.size()); end
    for (int i = 0; i < 16 && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_frame[i]) begin errors++; $display("FAIL bp_pix[%0d]: got %0d expected %0d", i, got_pix[i], exp_frame[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_size();
    bit busy_seen;
    clear_logs();
    @(negedge clk);
    src_w = 11'd2; src_h = 11'd2; dst_w = 11'd0; dst_h = 11'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zs_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zs_busy: got %b expected 0", busy); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL zs_mem_req: got %b expected 0", bus.mem_req); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zs_done_pulse: got %b expected 0", done); end
    busy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || bus.mem_req !== 1'b0) busy_seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (busy_seen) begin errors++; $display("FAIL zs_idle: got busy/mem_req activity expected none"); end
    checks++; if (rd_cnt != 0) begin errors++; $display("FAIL zs_reads: got %0d expected 0", rd_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zs_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_fetch();
    bit to;
    int n;
    clear_logs();
    start_frame(2, 2, 4, 4, 16'h0080, 16'h0080);
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rm_req_seen: got %b expected 1", bus.mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rm_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    start_frame(2, 2, 4, 4, 16'h0080, 16'h0080);
    wait_done(3000, to);
    repeat (2) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL rm_timeout: done not seen, got %0d pixels expected 16", got_pix.size()); end
    checks++; if (got_pix.size() != 16) begin errors++; $display("FAIL rm_count: got %0d expected 16", got_pix.size()); end
    for (int i = 0; i < 16 && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_frame[i]) begin errors++; $display("FAIL rm_pix[%0d]: got %0d expected %0d", i, got_pix[i], exp_frame[i]); end
    end
    checks++; if (rd_cnt != EXP_READS) begin errors++; $display("FAIL rm_reads: got %0d expected %0d", rd_cnt, EXP_READS); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rm_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    src_w = '0; src_h = '0; dst_w = '0; dst_h = '0;
    step_x = '0; step_y = '0;
    bus.out_ready = 1'b1;
    rd_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;

    test_reset();
    test_frame_4x4();
    test_single_pixel();
    test_backpressure();
    test_zero_size();
    test_reset_mid_fetch();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bilinear_scan_ctrl.md
Name: bilinear_scan_ctrl

Overview:
Sequencer for the single-cycle-registered bilinear interpolation datapath (Q0.8 alpha/beta, 8-bit pixels, valid_in -> valid_out one cycle later).
- Walks every destination pixel of a scaled frame in raster order and generates Q8.8 source coordinates by accumulation.
- Fetches the four neighbour pixels from a byte-wide source-frame memory through a req/ack port, then issues one interpolation.
- Streams results out under a valid/ready handshake.
- Sits between the frame buffer and the output pixel stream.

Parameters:
DIM_W, 11, width of frame width/height fields (max 2047)
ADDR_W, 22, source memory address width
BASE_ADDR, 0, byte address of source pixel (0,0)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; latch config, begin frame
src_w, src_h  in  DIM_W each  source dimensions
dst_w, dst_h  in  DIM_W each  destination dimensions
step_x, step_y  in  16 each  Q8.8 source increment per destination pixel/line
busy  out  1  high from start until done
done  out  1  one-cycle pulse after last pixel accepted
mem_req  out  1  read request
mem_addr  out  ADDR_W  read address
mem_ack  in  1  read complete; mem_rdata valid this cycle
mem_rdata  in  8  read data
ip_valid_in  out  1  to datapath valid_in
ip_I00, ip_I10, ip_I01, ip_I11  out  8 each  neighbour pixels to datapath
ip_alpha, ip_beta  out  8 each  Q0.8 fractions to datapath
ip_valid_out  in  1  from datapath valid_out
ip_pixel_out  in  8  from datapath pixel_out
out_valid  out  1  output stream valid
out_ready  in  1  output stream ready
out_pixel  out  8  output pixel
out_last  out  1  high with final pixel of frame

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All outputs 0; state IDLE; all counters and accumulators 0.
- Config: latched on start in IDLE; start ignored when busy=1.
- Zero-size frame: dst_w=0 or dst_h=0 -> IDLE->DONE with no memory traffic; done pulses the cycle after start.
- States:
  - IDLE: wait for start.
  - CALC, 1 cycle:
    - x0 = acc_x[DIM_W+7:8], alpha = acc_x[7:0]; likewise y0 and beta from acc_y.
    - x1 = min(x0+1, src_w-1); y1 = min(y0+1, src_h-1).
    - x0 and y0 saturate at src_w-1 and src_h-1.
  - FETCH: four reads, order I00 (x0,y0), I10 (x1,y0), I01 (x0,y1), I11 (x1,y1).
    - addr = BASE_ADDR + y*src_w + x.
    - mem_req and mem_addr held stable until mem_ack; one request outstanding at a time.
    - mem_rdata captured on mem_ack; mem_req drops for at least one cycle between reads.
  - ISSUE: ip_valid_in high exactly 1 cycle; ip_* operands held stable through WAIT.
  - WAIT: capture ip_pixel_out when ip_valid_out=1, one cycle after ISSUE.
  - OUTPUT: out_valid=1, out_pixel held stable until out_ready.
    - On accept: advance dx. acc_x += step_x.
    - At dx=dst_w-1: dx=0, acc_x=0, dy++, acc_y += step_y.
    - Last pixel -> DONE; otherwise -> CALC.
  - DONE: done=1 and busy=0 for 1 cycle -> IDLE.
- Accumulators: acc_x and acc_y are DIM_W+8 bits; an overflowing add saturates to all-ones (clamped through the x0/y0 saturation).
- out_last = out_valid and (dx=dst_w-1) and (dy=dst_h-1).
- Latency per pixel without stalls: CALC 1 + FETCH (4 ack latencies + gaps) + ISSUE 1 + WAIT 1 + OUTPUT >=1.
- Reset mid-operation: immediate return to IDLE; mem_req and out_valid drop asynchronously; an in-flight memory ack after reset is ignored.

Optional Feature:
BILINEAR_FETCH_REUSE_EN
- Defined: if (x0,y0) in CALC equals the previous pixel's (x0,y0) within the same frame, FETCH is skipped and the four held pixels are reused; only alpha/beta change.
- Undefined: every pixel performs four reads.
- Output pixels are identical either way.

Decomposition:
Package bilinear_pkg holds:
- state enum (IDLE, CALC, FETCH, ISSUE, WAIT, OUTPUT, DONE)
- 2-bit fetch index enum (F00, F10, F01, F11)
- constant Q_FRAC=8
- coordinate typedef sized DIM_W+8

One sub-module, bilinear_coord_gen: accumulators, dx/dy counters, x0/x1/y0/y1/alpha/beta and clamping, advanced by a step pulse.

Test Plan:
- 2x2 src {10,20;30,40}, dst 4x4, step 0x0080, ack latency 1 -> row0 outputs 10,15,20,20; row2 first pixel 30; out_last only on 16th; done once.
- dst 1x1, step 0x0100 -> single pixel 10, exactly 4 reads at addresses 0,1,2,3 with BASE_ADDR=0.
- Case 1 with out_ready low 5 cycles on pixel 2 -> out_pixel stays 15, no mem_req during stall, sequence unchanged.
- dst_w=0 -> no mem_req; done the cycle after start; busy never high beyond that cycle.
- rst asserted while mem_req high in FETCH -> mem_req=0 immediately; later start runs a full clean frame.
- Case 1 read count -> 64 reads without BILINEAR_FETCH_REUSE_EN, 32 with; output pixels identical.
